// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the RV32 5-stage pipeline.
// Multi-cycle EX ops (div/rem) are sequenced by a RUN/MC_WAIT FSM with a
// 4-bit down-counter. Optional performance counters are enabled by defining
// HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned MC_LATENCY = 4,
    parameter logic [2:0]  RES_LOAD   = 3'b001
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs1_addr_d,
    input  logic [4:0]  rs2_addr_d,
    input  logic        rs1_used_d,
    input  logic        rs2_used_d,
    input  logic [4:0]  rs1_addr_ex,
    input  logic [4:0]  rs2_addr_ex,
    input  logic [4:0]  reg_dest_addr_ex,
    input  logic        reg_write_ex,
    input  logic [2:0]  result_mux_sel_ex,
    input  logic [4:0]  reg_dest_addr_mem,
    input  logic        reg_write_mem,
    input  logic [4:0]  reg_dest_addr_wb,
    input  logic        reg_write_wb,
    input  logic        branch_taken_ex,
    input  logic        mc_start_ex,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_ex,
    output logic        flush_d,
    output logic        flush_ex,
    output logic        flush_mem,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_events_o,
`endif
    output logic        mc_busy_o
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(MC_LATENCY - 2);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use;
    logic       branch_run;

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use = (result_mux_sel_ex == RES_LOAD) && reg_write_ex &&
                   (reg_dest_addr_ex != 5'd0) &&
                   ((rs1_used_d && (rs1_addr_d == reg_dest_addr_ex)) ||
                    (rs2_used_d && (rs2_addr_d == reg_dest_addr_ex)));
    end

    // Next-state logic and stall/flush decode; reset forces every output low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_ex   = 1'b0;
        flush_d    = 1'b0;
        flush_ex   = 1'b0;
        flush_mem  = 1'b0;
        mc_busy_o  = 1'b0;
        branch_run = 1'b0;
        unique case (state_q)
            RUN: begin
                if (branch_taken_ex) begin
                    branch_run = 1'b1;
                    flush_d    = 1'b1;
                    flush_ex   = 1'b1;
                end else if (mc_start_ex) begin
                    stall_f   = 1'b1;
                    stall_d   = 1'b1;
                    stall_ex  = 1'b1;
                    flush_mem = 1'b1;
                    state_d   = MC_WAIT;
                    cnt_d     = CNT_INIT;
                end else if (load_use) begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    flush_ex = 1'b1;
                end
            end
            MC_WAIT: begin
                stall_f   = 1'b1;
                stall_d   = 1'b1;
                stall_ex  = 1'b1;
                flush_mem = 1'b1;
                mc_busy_o = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
        if (rst_i) begin
            stall_f    = 1'b0;
            stall_d    = 1'b0;
            stall_ex   = 1'b0;
            flush_d    = 1'b0;
            flush_ex   = 1'b0;
            flush_mem  = 1'b0;
            mc_busy_o  = 1'b0;
            branch_run = 1'b0;
        end
    end

    // Operand forwarding: MEM beats WB, x0 never forwards.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (reg_write_mem && (reg_dest_addr_mem != 5'd0) && (reg_dest_addr_mem == rs1_addr_ex))
            fwd_a_sel = 2'b10;
        else if (reg_write_wb && (reg_dest_addr_wb != 5'd0) && (reg_dest_addr_wb == rs1_addr_ex))
            fwd_a_sel = 2'b01;
        if (reg_write_mem && (reg_dest_addr_mem != 5'd0) && (reg_dest_addr_mem == rs2_addr_ex))
            fwd_b_sel = 2'b10;
        else if (reg_write_wb && (reg_dest_addr_wb != 5'd0) && (reg_dest_addr_wb == rs2_addr_ex))
            fwd_b_sel = 2'b01;
        if (rst_i) begin
            fwd_a_sel = 2'b00;
            fwd_b_sel = 2'b00;
        end
    end

    // FSM state and latency counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    // Saturating event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (stall_f && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (branch_run && (flush_events_q != '1))
            flush_events_d = flush_events_q + 32'd1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_events_o = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (default build).
module tb_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] rs1_addr_d, rs2_addr_d, rs1_addr_ex, rs2_addr_ex;
    logic       rs1_used_d, rs2_used_d;
    logic [4:0] reg_dest_addr_ex, reg_dest_addr_mem, reg_dest_addr_wb;
    logic       reg_write_ex, reg_write_mem, reg_write_wb;
    logic [2:0] result_mux_sel_ex;
    logic       branch_taken_ex, mc_start_ex;
    logic       stall_f, stall_d, stall_ex, flush_d, flush_ex, flush_mem, mc_busy_o;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    int checks = 0;
    int errors = 0;

    // {stall_f, stall_d, stall_ex, flush_d, flush_ex, flush_mem, mc_busy_o}
    logic [6:0] ctl;
    assign ctl = {stall_f, stall_d, stall_ex, flush_d, flush_ex, flush_mem, mc_busy_o};

    hazard_ctrl #(.MC_LATENCY(4), .RES_LOAD(3'b001)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rs1_addr_d(rs1_addr_d), .rs2_addr_d(rs2_addr_d),
        .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
        .rs1_addr_ex(rs1_addr_ex), .rs2_addr_ex(rs2_addr_ex),
        .reg_dest_addr_ex(reg_dest_addr_ex), .reg_write_ex(reg_write_ex),
        .result_mux_sel_ex(result_mux_sel_ex),
        .reg_dest_addr_mem(reg_dest_addr_mem), .reg_write_mem(reg_write_mem),
        .reg_dest_addr_wb(reg_dest_addr_wb), .reg_write_wb(reg_write_wb),
        .branch_taken_ex(branch_taken_ex), .mc_start_ex(mc_start_ex),
        .stall_f(stall_f), .stall_d(stall_d), .stall_ex(stall_ex),
        .flush_d(flush_d), .flush_ex(flush_ex), .flush_mem(flush_mem),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mc_busy_o(mc_busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Quiet pipeline: no hazards, no forwarding.
    task automatic idle_inputs();
        rs1_addr_d = 5'd1; rs2_addr_d = 5'd2; rs1_used_d = 1'b0; rs2_used_d = 1'b0;
        rs1_addr_ex = 5'd3; rs2_addr_ex = 5'd4;
        reg_dest_addr_ex = 5'd0; reg_write_ex = 1'b0; result_mux_sel_ex = 3'b000;
        reg_dest_addr_mem = 5'd0; reg_write_mem = 1'b0;
        reg_dest_addr_wb = 5'd0; reg_write_wb = 1'b0;
        branch_taken_ex = 1'b0; mc_start_ex = 1'b0;
    endtask

    // Advance to 1 time unit after the next rising edge; inputs change here.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Load x5 in EX, ID reading x5 through rs1.
    task automatic set_load_use();
        result_mux_sel_ex = 3'b001; reg_write_ex = 1'b1; reg_dest_addr_ex = 5'd5;
        rs1_addr_d = 5'd5; rs1_used_d = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle_inputs();
        set_load_use();
        branch_taken_ex = 1'b1;
        reg_write_mem = 1'b1; reg_dest_addr_mem = 5'd3;
        rs2_addr_ex = 5'd3;
        next_cycle();
        #3;
        checks++;
        if (ctl !== 7'b0) begin
            errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 7'b0);
        end
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0) begin
            errors++; $display("FAIL reset_fwd got %b exp %b", {fwd_a_sel, fwd_b_sel}, 4'b0);
        end
        next_cycle();
        rst_i = 1'b0;
        idle_inputs();
        #3;
        checks++;
        if (ctl !== 7'b0) begin
            errors++; $display("FAIL after_reset_ctl got %b exp %b", ctl, 7'b0);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        idle_inputs();
        set_load_use();
        #3;
        checks++;
        if (ctl !== 7'b1100100) begin
            errors++; $display("FAIL load_use_hit got %b exp %b", ctl, 7'b1100100);
        end
        // Load advanced to MEM; the dependent instruction now sits in EX.
        next_cycle();
        idle_inputs();
        reg_dest_addr_mem = 5'd5; reg_write_mem = 1'b1; rs1_addr_ex = 5'd5;
        #3;
        checks++;
        if (ctl !== 7'b0) begin
            errors++; $display("FAIL load_use_release got %b exp %b", ctl, 7'b0);
        end
        checks++;
        if (fwd_a_sel !== 2'b10) begin
            errors++; $display("FAIL load_use_fwd got %b exp %b", fwd_a_sel, 2'b10);
        end
        // rs2 path also detects the hazard.
        next_cycle();
        idle_inputs();
        result_mux_sel_ex = 3'b001; reg_write_ex = 1'b1; reg_dest_addr_ex = 5'd9;
        rs2_addr_d = 5'd9; rs2_used_d = 1'b1;
        #3;
        checks++;
        if (ctl !== 7'b1100100) begin
            errors++; $display("FAIL load_use_rs2 got %b exp %b", ctl, 7'b1100100);
        end
    endtask

    task automatic test_load_use_negative();
        for (int unsigned k = 0; k < 4; k++) begin
            next_cycle();
            idle_inputs();
            set_load_use();
            case (k)
                0: begin reg_dest_addr_ex = 5'd0; rs1_addr_d = 5'd0; end
                1: rs1_used_d = 1'b0;
                2: result_mux_sel_ex = 3'b000;
                default: reg_write_ex = 1'b0;
            endcase
            #3;
            checks++;
            if (ctl !== 7'b0) begin
                errors++; $display("FAIL load_use_neg%0d got %b exp %b", k, ctl, 7'b0);
            end
        end
    endtask

    // Full MC_LATENCY=4 sequence starting with the mc_start cycle.
    task automatic run_mc(input string tag);
        logic [6:0] exp_ctl [5];
        exp_ctl[0] = 7'b1110010;
        exp_ctl[1] = 7'b1110011;
        exp_ctl[2] = 7'b1110011;
        exp_ctl[3] = 7'b1110011;
        exp_ctl[4] = 7'b0000000;
        next_cycle();
        idle_inputs();
        mc_start_ex = 1'b1;
        for (int unsigned c = 0; c < 5; c++) begin
            if (c == 1) begin
                // Inputs in MC_WAIT must be ignored.
                branch_taken_ex = 1'b1;
                set_load_use();
            end
            if (c == 4) idle_inputs();
            #3;
            checks++;
            if (ctl !== exp_ctl[c]) begin
                errors++; $display("FAIL %s_cycle%0d got %b exp %b", tag, c + 1, ctl, exp_ctl[c]);
            end
            if (c < 4) next_cycle();
        end
    endtask

    task automatic test_multicycle();
        run_mc("mc");
    endtask

    task automatic test_branch();
        next_cycle();
        idle_inputs();
        set_load_use();
        branch_taken_ex = 1'b1;
        #3;
        checks++;
        if (ctl !== 7'b0001100) begin
            errors++; $display("FAIL branch_load_use got %b exp %b", ctl, 7'b0001100);
        end
        // Branch beats mc_start: FSM must stay in RUN.
        next_cycle();
        idle_inputs();
        branch_taken_ex = 1'b1; mc_start_ex = 1'b1;
        #3;
        checks++;
        if (ctl !== 7'b0001100) begin
            errors++; $display("FAIL branch_mc got %b exp %b", ctl, 7'b0001100);
        end
        next_cycle();
        idle_inputs();
        #3;
        checks++;
        if (ctl !== 7'b0) begin
            errors++; $display("FAIL branch_mc_stay_run got %b exp %b", ctl, 7'b0);
        end
    endtask

    task automatic test_forwarding();
        logic [4:0] mem_d [5] = '{5'd7, 5'd7, 5'd0, 5'd8, 5'd7};
        logic       mem_w [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0] wb_d  [5] = '{5'd7, 5'd7, 5'd0, 5'd7, 5'd8};
        logic       wb_w  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] exp_a [5] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b10};
        logic [1:0] exp_b [5] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
        for (int unsigned k = 0; k < 5; k++) begin
            next_cycle();
            idle_inputs();
            rs1_addr_ex = 5'd7; rs2_addr_ex = 5'd8;
            reg_dest_addr_mem = mem_d[k]; reg_write_mem = mem_w[k];
            reg_dest_addr_wb = wb_d[k]; reg_write_wb = wb_w[k];
            #3;
            checks++;
            if (fwd_a_sel !== exp_a[k]) begin
                errors++; $display("FAIL fwd_a%0d got %b exp %b", k, fwd_a_sel, exp_a[k]);
            end
            checks++;
            if (fwd_b_sel !== exp_b[k]) begin
                errors++; $display("FAIL fwd_b%0d got %b exp %b", k, fwd_b_sel, exp_b[k]);
            end
        end
        // Forwarding stays active during MC_WAIT.
        next_cycle();
        idle_inputs();
        mc_start_ex = 1'b1;
        next_cycle();
        idle_inputs();
        rs1_addr_ex = 5'd7; reg_dest_addr_wb = 5'd7; reg_write_wb = 1'b1;
        #3;
        checks++;
        if ({mc_busy_o, fwd_a_sel} !== 3'b101) begin
            errors++; $display("FAIL fwd_in_wait got %b exp %b", {mc_busy_o, fwd_a_sel}, 3'b101);
        end
        for (int unsigned c = 0; c < 3; c++) next_cycle();
    endtask

    task automatic test_reset_mid_mc();
        next_cycle();
        idle_inputs();
        mc_start_ex = 1'b1;
        next_cycle();
        idle_inputs();
        #3;
        checks++;
        if (ctl !== 7'b1110011) begin
            errors++; $display("FAIL rst_mc_wait got %b exp %b", ctl, 7'b1110011);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'b0) begin
            errors++; $display("FAIL rst_mc_forced got %b exp %b", ctl, 7'b0);
        end
        next_cycle();
        rst_i = 1'b0;
        #3;
        checks++;
        if (ctl !== 7'b0) begin
            errors++; $display("FAIL rst_mc_run got %b exp %b", ctl, 7'b0);
        end
        next_cycle();
        #3;
        checks++;
        if (ctl !== 7'b0) begin
            errors++; $display("FAIL rst_mc_no_pulse got %b exp %b", ctl, 7'b0);
        end
        run_mc("mc_after_rst");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_use_negative();
        test_multicycle();
        test_branch();
        test_forwarding();
        test_reset_mid_mc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
